npu_tile_scheduler: RTL and testbench

//  Sequences one command over a rectangular range of the 8x8 tile grid: one start per tile to the tile processor.

---
 rtl/npu_tile_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_npu_tile_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_tile_scheduler.sv
// npu_tile_scheduler: walks a tile range of the 8x8 grid, one tp_start per tile,
// and muxes SRAM ownership. Optional WAIT timeout: define NPU_SCHED_TIMEOUT_EN.
module npu_tile_scheduler #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_i0,
  input  logic [2:0] cmd_i1,
  input  logic [2:0] cmd_j0,
  input  logic [2:0] cmd_j1,
  input  logic       host_req,
  output logic       host_gnt,
  output logic       sram_sel,
  output logic       tp_start,
  output logic [2:0] tp_tile_i,
  output logic [2:0] tp_tile_j,
  output logic [2:0] tp_op_code,
  input  logic       tp_done,
  output logic       busy,
  output logic [6:0] tiles_done,
  output logic       irq,
  output logic       err_cmd,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0] r_op;
  logic [2:0] r_i1;
  logic [2:0] r_j0;
  logic [2:0] r_j1;
  logic [2:0] r_ti;
  logic [2:0] r_tj;
  logic [6:0] r_tiles;
  logic       r_err_cmd;
  logic       r_done_q;

  logic w_acc;
  logic w_bad;
  logic w_edge;
  logic w_row_end;
  logic w_last;
  logic w_to;

  // counter width must be able to hold the timeout limit
  if (TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_to_w_too_small
    logic w_to_w_too_small;
    assign w_to_w_too_small = 1'b1;
  end

  assign w_acc     = (r_state == S_IDLE) & cmd_valid & ~host_req;
  assign w_bad     = (cmd_op > 3'd4) | (cmd_i0 > cmd_i1) | (cmd_j0 > cmd_j1);
  assign w_edge    = tp_done & ~r_done_q;
  assign w_row_end = (r_tj == r_j1);
  assign w_last    = w_row_end & (r_ti == r_i1);

`ifdef NPU_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err_to;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  assign w_to        = (r_state == S_WAIT) & ~w_edge & (r_to_cnt == TO_LAST);
  assign err_timeout = r_err_to;

  // WAIT watchdog: cleared on each issue, sticky error until next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_err_to <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_to_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_acc) begin
        r_err_to <= 1'b0;
      end else if (w_to) begin
        r_err_to <= 1'b1;
      end
    end
  end
`else
  assign w_to        = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state and state-decoded outputs
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    host_gnt  = 1'b0;
    sram_sel  = 1'b0;
    busy      = 1'b0;
    tp_start  = 1'b0;
    irq       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        host_gnt  = host_req;
        cmd_ready = ~host_req;
        if (w_acc) begin
          w_next = w_bad ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        sram_sel = 1'b1;
        busy     = 1'b1;
        tp_start = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        sram_sel = 1'b1;
        busy     = 1'b1;
        if (w_edge) begin
          w_next = S_NEXT;
        end else if (w_to) begin
          w_next = S_FIN;
        end
      end
      S_NEXT: begin
        sram_sel = 1'b1;
        busy     = 1'b1;
        w_next   = w_last ? S_FIN : S_ISSUE;
      end
      S_FIN: begin
        irq    = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // command latch, tile walker, completion count and reject flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_i1      <= '0;
      r_j0      <= '0;
      r_j1      <= '0;
      r_ti      <= '0;
      r_tj      <= '0;
      r_tiles   <= '0;
      r_err_cmd <= 1'b0;
      r_done_q  <= 1'b0;
    end else begin
      r_done_q <= tp_done;
      if (w_acc) begin
        r_op      <= cmd_op;
        r_i1      <= cmd_i1;
        r_j0      <= cmd_j0;
        r_j1      <= cmd_j1;
        r_tiles   <= '0;
        r_err_cmd <= w_bad;
        if (!w_bad) begin
          r_ti <= cmd_i0;
          r_tj <= cmd_j0;
        end
      end
      if ((r_state == S_WAIT) && w_edge) begin
        r_tiles <= r_tiles + 7'd1;
      end
      if ((r_state == S_NEXT) && !w_last) begin
        if (w_row_end) begin
          r_tj <= r_j0;
          r_ti <= r_ti + 3'd1;
        end else begin
          r_tj <= r_tj + 3'd1;
        end
      end
    end
  end

  assign tp_tile_i  = r_ti;
  assign tp_tile_j  = r_tj;
  assign tp_op_code = r_op;
  assign tiles_done = r_tiles;
  assign err_cmd    = r_err_cmd;

endmodule

// File: tb/tb_npu_tile_scheduler.sv
// tb_npu_tile_scheduler: timeline model of command/tile/irq behaviour
// plus directed held-high, timeout and async-reset cases.
`timescale 1ns/1ps
module tb_npu_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [2:0] cmd_i0 = '0;
  logic [2:0] cmd_i1 = '0;
  logic [2:0] cmd_j0 = '0;
  logic [2:0] cmd_j1 = '0;
  logic       host_req = 1'b0;
  logic       host_gnt;
  logic       sram_sel;
  logic       tp_start;
  logic [2:0] tp_tile_i;
  logic [2:0] tp_tile_j;
  logic [2:0] tp_op_code;
  logic       tp_done = 1'b0;
  logic       busy;
  logic [6:0] tiles_done;
  logic       irq;
  logic       err_cmd;
  logic       err_timeout;

  npu_tile_scheduler #(.TIMEOUT_CYCLES(16), .TO_W(13)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_i0(cmd_i0), .cmd_i1(cmd_i1), .cmd_j0(cmd_j0), .cmd_j1(cmd_j1),
    .host_req(host_req), .host_gnt(host_gnt), .sram_sel(sram_sel),
    .tp_start(tp_start), .tp_tile_i(tp_tile_i), .tp_tile_j(tp_tile_j),
    .tp_op_code(tp_op_code), .tp_done(tp_done), .busy(busy),
    .tiles_done(tiles_done), .irq(irq), .err_cmd(err_cmd),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model of the current command: accept cycle, tile list, done delay
  bit       m_on = 1'b0;
  int       m_A = -100;
  int       m_N = 0;
  int       m_D = 1;
  bit       m_bad = 1'b0;
  bit [2:0] m_op = '0;
  int       m_prev_tiles = 0;
  bit       m_prev_err = 1'b0;
  int       m_list[$];

  function automatic int m_per();
    return m_D + 2;
  endfunction

  function automatic int m_irq_cyc();
    return m_A + 1 + m_N * m_per();
  endfunction

  function automatic bit m_busy(input int c);
    return (c >= m_A + 1) && (c <= m_A + m_N * m_per());
  endfunction

  function automatic bit m_idle(input int c);
    return (c <= m_A) || (c > m_irq_cyc());
  endfunction

  function automatic int m_start_k(input int c);
    int d;
    d = c - m_A - 1;
    if (d >= 0 && (d % m_per()) == 0 && (d / m_per()) < m_N)
      return d / m_per();
    return -1;
  endfunction

  function automatic int m_tiles(input int c);
    int n;
    if (c <= m_A) return m_prev_tiles;
    n = 0;
    for (int k = 0; k < m_N; k++)
      if (m_A + 1 + k * m_per() + m_D + 1 <= c) n++;
    return n;
  endfunction

  function automatic bit m_err(input int c);
    return (c <= m_A) ? m_prev_err : m_bad;
  endfunction

  // tile processor stand-in: done pulse D cycles after each start
  bit agent_en = 1'b1;
  int agent_D = 1;
  int last_done = 0;

  always begin
    @(negedge clk);
    if (agent_en && tp_start) begin
      repeat (agent_D) @(posedge clk);
      #1 tp_done = 1'b1;
      last_done = cyc;
      @(posedge clk);
      #1 tp_done = 1'b0;
    end
  end

  int cnt_start = 0;
  int cnt_irq = 0;
  int last_irq = 0;
  int obs[$];

  // every-cycle comparison against the model
  always @(negedge clk) begin
    int c;
    int k;
    bit id;
    if (m_on) begin
      c = cyc;
      k = m_start_k(c);
      id = m_idle(c);
      chk("tp_start", tp_start, k >= 0);
      if (tp_start) begin
        cnt_start++;
        obs.push_back(int'({tp_tile_i, tp_tile_j}));
        if (k >= 0 && k < m_list.size()) begin
          chk("tile", {tp_tile_i, tp_tile_j}, m_list[k]);
          chk("op", tp_op_code, m_op);
        end
      end
      chk("busy", busy, m_busy(c));
      chk("sram_sel", sram_sel, m_busy(c));
      chk("irq", irq, c == m_irq_cyc());
      if (irq) begin
        cnt_irq++;
        last_irq = c;
      end
      chk("cmd_ready", cmd_ready, id && !host_req);
      chk("host_gnt", host_gnt, id && host_req);
      chk("tiles_done", tiles_done, m_tiles(c));
      chk("err_cmd", err_cmd, m_err(c));
      chk("err_timeout", err_timeout, 0);
    end
  end

  task automatic wait_idle();
    for (int n = 0; n < 2000 && cyc <= m_irq_cyc() + 1; n++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // offer a command; host_req shadows it for hw cycles first
  task automatic launch(input logic [2:0] op, input logic [2:0] i0,
                        input logic [2:0] i1, input logic [2:0] j0,
                        input logic [2:0] j1, input int d, input int hw);
    wait_idle();
    m_prev_tiles = m_tiles(cyc);
    m_prev_err = m_err(cyc);
    agent_D = d;
    cmd_op = op; cmd_i0 = i0; cmd_i1 = i1; cmd_j0 = j0; cmd_j1 = j1;
    cmd_valid = 1'b1;
    host_req = (hw > 0);
    for (int n = 0; n < hw; n++) begin
      #3;
      chk("arb_gnt", host_gnt, 1);
      chk("arb_ready", cmd_ready, 0);
      @(posedge clk);
      #1;
    end
    host_req = 1'b0;
    m_list.delete();
    m_bad = (op > 3'd4) || (i0 > i1) || (j0 > j1);
    if (!m_bad)
      for (int i = int'(i0); i <= int'(i1); i++)
        for (int j = int'(j0); j <= int'(j1); j++)
          m_list.push_back(i * 8 + j);
    m_op = op;
    m_D = d;
    m_N = m_list.size();
    m_A = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  int s0;
  int i0_;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_gnt", host_gnt, 0);
    chk("rst_sel", sram_sel, 0);
    chk("rst_start", tp_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tiles", tiles_done, 0);
    chk("rst_irq", irq, 0);
    chk("rst_err", {err_cmd, err_timeout}, 0);
    chk("rst_tile", {tp_op_code, tp_tile_i, tp_tile_j}, 0);
    @(posedge clk);
    #1 m_on = 1'b1;

    // single tile (2,5), done 10 cycles after start
    s0 = cnt_start; i0_ = cnt_irq; obs.delete();
    launch(3'd0, 3'd2, 3'd2, 3'd5, 3'd5, 10, 0);
    wait_idle();
    chk("single_starts", cnt_start - s0, 1);
    chk("single_tile", obs.size() > 0 ? obs[0] : -1, 21);
    chk("single_tiles", tiles_done, 1);
    chk("single_irq_n", cnt_irq - i0_, 1);
    chk("single_irq_lat", last_irq - m_A, 13);
    chk("single_done_irq", last_irq - last_done, 2);

    // rows 0..1, cols 6..7, row-major
    s0 = cnt_start; i0_ = cnt_irq; obs.delete();
    launch(3'd1, 3'd0, 3'd1, 3'd6, 3'd7, 3, 0);
    wait_idle();
    chk("rng_n", obs.size(), 4);
    chk("rng_o0", obs.size() > 0 ? obs[0] : -1, 6);
    chk("rng_o1", obs.size() > 1 ? obs[1] : -1, 7);
    chk("rng_o2", obs.size() > 2 ? obs[2] : -1, 14);
    chk("rng_o3", obs.size() > 3 ? obs[3] : -1, 15);
    chk("rng_tiles", tiles_done, 4);
    chk("rng_irq_n", cnt_irq - i0_, 1);

    // host wins over a pending command, then never preempts
    launch(3'd2, 3'd1, 3'd1, 3'd0, 3'd1, 4, 3);
    repeat (3) @(posedge clk);
    #1 host_req = 1'b1;
    #3 chk("mid_gnt", host_gnt, 0);
    wait_idle();
    #3 chk("post_gnt", host_gnt, 1);
    @(posedge clk);
    #1 host_req = 1'b0;

    // rejects: bad op, then inverted rows
    s0 = cnt_start;
    launch(3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 1, 0);
    wait_idle();
    chk("rej_op_err", err_cmd, 1);
    chk("rej_op_lat", last_irq - m_A, 1);
    chk("rej_op_tiles", tiles_done, 0);
    launch(3'd0, 3'd4, 3'd3, 3'd0, 3'd0, 1, 0);
    wait_idle();
    chk("rej_row_err", err_cmd, 1);
    chk("rej_starts", cnt_start - s0, 0);

    // valid command clears the sticky reject
    obs.delete();
    launch(3'd4, 3'd7, 3'd7, 3'd7, 3'd7, 1, 0);
    wait_idle();
    chk("clr_err", err_cmd, 0);
    chk("corner_tile", obs.size() > 0 ? obs[0] : -1, 63);

    // whole grid
    s0 = cnt_start; obs.delete();
    launch(3'd3, 3'd0, 3'd7, 3'd0, 3'd7, 1, 0);
    wait_idle();
    chk("grid_starts", cnt_start - s0, 64);
    chk("grid_tiles", tiles_done, 64);
    chk("grid_last", obs.size() > 63 ? obs[63] : -1, 63);

    // single column walk
    obs.delete();
    launch(3'd3, 3'd3, 3'd5, 3'd0, 3'd0, 2, 0);
    wait_idle();
    chk("col_o2", obs.size() > 2 ? obs[2] : -1, 40);
    chk("col_tiles", tiles_done, 3);

    m_on = 1'b0;
    agent_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // tp_done held high from tile 0 must not complete tile 1
    cmd_op = 3'd2; cmd_i0 = 3'd0; cmd_i1 = 3'd0; cmd_j0 = 3'd0; cmd_j1 = 3'd1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int n = 0; n < 20 && !tp_start; n++) @(negedge clk);
    chk("hh_start1", tp_start, 1);
    @(posedge clk);
    @(posedge clk);
    #1 tp_done = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 20 && !tp_start; n++) @(negedge clk);
    chk("hh_start2", tp_start, 1);
    repeat (8) @(negedge clk);
    chk("hh_tiles", tiles_done, 1);
    chk("hh_busy", busy, 1);
    @(posedge clk);
    #1 tp_done = 1'b0;
    @(posedge clk);
    #1 tp_done = 1'b1;
    @(posedge clk);
    #1 tp_done = 1'b0;
    for (int n = 0; n < 10 && !irq; n++) @(negedge clk);
    chk("hh_irq", irq, 1);
    chk("hh_tiles2", tiles_done, 2);

`ifdef NPU_SCHED_TIMEOUT_EN
    // no done at all: abort after the WAIT limit
    repeat (2) @(posedge clk);
    #1 cmd_op = 3'd0; cmd_i0 = 3'd1; cmd_i1 = 3'd2; cmd_j0 = 3'd1; cmd_j1 = 3'd1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int n = 0; n < 60 && !irq; n++) @(negedge clk);
    chk("to_irq", irq, 1);
    chk("to_err", err_timeout, 1);
    chk("to_tiles", tiles_done, 0);
    chk("to_sel", sram_sel, 0);
`endif

    // async reset in the middle of a command
    repeat (2) @(posedge clk);
    #1 cmd_op = 3'd1; cmd_i0 = 3'd0; cmd_i1 = 3'd0; cmd_j0 = 3'd0; cmd_j1 = 3'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int n = 0; n < 20 && !tp_start; n++) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_sel", sram_sel, 0);
    chk("ar_busy", busy, 0);
    chk("ar_irq", irq, 0);
    chk("ar_tiles", tiles_done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_ready", cmd_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
